// File: rtl/dcache_dm_wb.sv
// Direct-mapped, write-back, write-allocate data cache: 32-bit word port to a 128-bit line memory.
// Define DCACHE_PERF_CNT_EN to add saturating hit_cnt/miss_cnt output ports.
module dcache_dm_wb #(
  parameter int LINE_NUM = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic         proc_stall,
  output logic [31:0]  proc_rdata,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt
`endif
);

  localparam int IDX_W = $clog2(LINE_NUM);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {COMPARE, WRITEBACK, ALLOCATE} state_e;

  state_e              state_q, state_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [LINE_NUM-1:0] valid_q, valid_d;
  logic [LINE_NUM-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]    tag_q  [LINE_NUM];
  logic [TAG_W-1:0]    tag_d  [LINE_NUM];
  logic [127:0]        data_q [LINE_NUM];
  logic [127:0]        data_d [LINE_NUM];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] addr_tag;
  logic [6:0]       word_lsb;
  logic             req;
  logic             hit;

  assign idx      = proc_addr[IDX_W+1:2];
  assign addr_tag = proc_addr[29:IDX_W+2];
  assign word_lsb = {proc_addr[1:0], 5'd0};
  assign req      = proc_read | proc_write;
  assign hit      = valid_q[idx] & (tag_q[idx] == addr_tag);

  assign proc_stall = (state_q != COMPARE) | (req & ~hit);
  assign proc_rdata = data_q[idx][word_lsb +: 32];
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = (state_q == WRITEBACK) ? {tag_q[idx], idx} : proc_addr[29:2];
  assign mem_wdata  = data_q[idx];

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    tag_d       = tag_q;
    data_d      = data_q;
    case (state_q)
      COMPARE: begin
        if (req && !hit) begin
          if (valid_q[idx] && dirty_q[idx]) begin
            state_d     = WRITEBACK;
            mem_write_d = 1'b1;
          end else begin
            state_d    = ALLOCATE;
            mem_read_d = 1'b1;
          end
        end else if (proc_write) begin
          // Write hit: only the addressed word changes; write wins over a concurrent read.
          data_d[idx][word_lsb +: 32] = proc_wdata;
          dirty_d[idx]                = 1'b1;
        end
      end
      WRITEBACK: begin
        if (mem_ready) begin
          state_d     = ALLOCATE;
          mem_write_d = 1'b0;
          mem_read_d  = 1'b1;
        end
      end
      ALLOCATE: begin
        if (mem_ready) begin
          state_d      = COMPARE;
          mem_read_d   = 1'b0;
          data_d[idx]  = mem_rdata;
          tag_d[idx]   = addr_tag;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
        end
      end
      default: begin
        state_d     = COMPARE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= COMPARE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      valid_q     <= '0;
      dirty_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
    end
  end

  // NOTE: tag and data storage is deliberately not reset; valid_q qualifies every use of it.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == COMPARE && req && hit && hit_cnt_q != 32'hFFFF_FFFF)
      hit_cnt_d = hit_cnt_q + 32'd1;
    if (state_q == COMPARE && req && !hit && miss_cnt_q != 32'hFFFF_FFFF)
      miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule
